// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, the fetch PC step and the {pc, instr} fetch entry type
package rv32i_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem req/gnt/rvalid read bus plus the decode valid/ready handshake
// master = fetch unit (drives imem_req/imem_addr and if_valid/if_pc/if_instr)
// slave  = memory + decode side (drives imem_gnt/imem_rvalid/imem_rdata and if_ready)
interface instr_fetch_unit_if;
  import rv32i_pkg::*;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [ILEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
  logic            if_ready;
  modport master(
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
  modport slave(
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fifo.sv
// fetch_fifo: sync FIFO of fetch_entry_t with flush; ports clk/rst/flush, push/din, pop/dout, count
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  fetch_entry_t           din,
  input  logic                   pop,
  output fetch_entry_t           dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop = pop && count != '0;
  // a pop frees the slot in the same cycle, so push is legal even when full
  assign do_push = push && (count != FULL || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp <= wp + AW'(1);
      end
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns fetch PC, issues in-order imem reads, buffers {pc,instr} for decode
// ports: clk, rst (sync, active-high), redirect_valid/redirect_pc (EX redirect),
//        bus (master: imem req/addr/gnt/rvalid/rdata, if_valid/pc/instr/ready)
module instr_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2,
  parameter int              MAX_OUTST  = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  instr_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int QW = $clog2(MAX_OUTST);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] aq [MAX_OUTST];
  logic [QW-1:0] aq_w, aq_r;
  logic [CW-1:0] outst_cnt, drop_cnt, fifo_cnt;
  logic gnt_ok, ret, keep;
  fetch_entry_t ret_entry, head;
  // credits: every granted request already owns a FIFO slot for its return
  assign bus.imem_req = !rst && !redirect_valid && (outst_cnt + fifo_cnt < DEPTH_C) && (outst_cnt < MAX_C);
  assign bus.imem_addr = fetch_pc;
  assign gnt_ok = bus.imem_req && bus.imem_gnt;
  assign ret = bus.imem_rvalid;
  assign keep = ret && drop_cnt == '0;
  assign ret_entry = '{pc: aq[aq_r], instr: bus.imem_rdata};
  assign bus.if_valid = !rst && fifo_cnt != '0;
  assign bus.if_pc = bus.if_valid ? head.pc : '0;
  assign bus.if_instr = bus.if_valid ? head.instr : '0;
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (keep),
    .din   (ret_entry),
    .pop   (bus.if_valid && bus.if_ready),
    .dout  (head),
    .count (fifo_cnt)
  );
  // the address queue is not flushed on redirect: dropped returns still pop it
  always_ff @(posedge clk)
    if (rst) begin
      fetch_pc <= RESET_PC;
      outst_cnt <= '0;
      drop_cnt <= '0;
      aq_w <= '0;
      aq_r <= '0;
    end else begin
      if (gnt_ok) begin
        aq[aq_w] <= fetch_pc;
        aq_w <= aq_w + QW'(1);
      end
      if (ret) aq_r <= aq_r + QW'(1);
      outst_cnt <= outst_cnt + CW'(gnt_ok) - CW'(ret);
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        drop_cnt <= outst_cnt - CW'(ret);
      end else begin
        if (gnt_ok) fetch_pc <= fetch_pc + PC_STEP;
        if (ret && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      end
    end
endmodule
